// File: rtl/rr_mux_arbiter_if.sv
// ============================================================================
// rr_mux_arbiter_if : requester/downstream bundle of the round-robin mux.
// Rev 1.0
// ============================================================================
`default_nettype none

interface rr_mux_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT   = 5,
  parameter int SRC_W = 3
);
  logic [CNT-1:0]       in_vld;
  logic [CNT-1:0]       in_last;
  logic [WIDTH*CNT-1:0] in_data;
  logic [CNT-1:0]       in_rdy;
  logic [CNT-1:0]       grant;
  logic                 out_vld;
  logic                 out_last;
  logic [WIDTH-1:0]     out_data;
  logic [SRC_W-1:0]     out_src;
  logic                 out_rdy;

  // Arbiter side
  modport slave (
    input  in_vld, in_last, in_data, out_rdy,
    output in_rdy, grant, out_vld, out_last, out_data, out_src
  );

  // Requester / downstream side
  modport master (
    output in_vld, in_last, in_data, out_rdy,
    input  in_rdy, grant, out_vld, out_last, out_data, out_src
  );
endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// rr_mux_arbiter : packet-granular round-robin N:1 mux with a registered output beat.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT   = 5,
  parameter int SRC_W = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rr_mux_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [SRC_W-1:0]     ptr_q;
  logic [CNT-1:0]       grant_q;
  logic                 out_vld_q;
  logic                 out_last_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SRC_W-1:0]     out_src_q;

  logic [CNT-1:0]       grant_d;
  logic [SRC_W-1:0]     ptr_d;
  logic [CNT-1:0]       in_rdy_w;
  logic                 accept_w;
  logic [WIDTH-1:0]     mux_data_w;
  logic                 mux_last_w;
  logic [SRC_W-1:0]     mux_src_w;

  // Round-robin winner search, starting at ptr_q and wrapping modulo CNT.
  always_comb begin
    int  idx;
    logic found;
    grant_d = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < CNT; k++) begin
      idx = (int'(ptr_q) + k) % CNT;
      if (!found && bus.in_vld[idx]) begin
        grant_d[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // The output register can take a new beat when empty or draining this cycle.
  assign in_rdy_w = grant_q & {CNT{~out_vld_q | bus.out_rdy}};
  assign accept_w = |(bus.in_vld & in_rdy_w);

  always_comb begin
    mux_data_w = '0;
    mux_last_w = 1'b0;
    mux_src_w  = '0;
    for (int i = 0; i < CNT; i++) begin
      mux_data_w = mux_data_w | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
      mux_last_w = mux_last_w | (bus.in_last[i] & grant_q[i]);
      if (grant_q[i]) begin
        mux_src_w = mux_src_w | SRC_W'(i);
      end
    end
  end

  assign ptr_d = (mux_src_w == SRC_W'(CNT - 1)) ? '0 : mux_src_w + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.in_vld) begin
            grant_q <= grant_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Grant survives bubbles; only an accepted last beat ends the packet.
          if (accept_w && mux_last_w) begin
            grant_q <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase

      if (accept_w) begin
        out_vld_q  <= 1'b1;
        out_last_q <= mux_last_w;
        out_data_q <= mux_data_w;
        out_src_q  <= mux_src_w;
      end else if (bus.out_rdy) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign bus.in_rdy   = in_rdy_w;
  assign bus.grant    = grant_q;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_last = out_last_q;
  assign bus.out_data = out_data_q;
  assign bus.out_src  = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// tb_rr_mux_arbiter : directed self-checking bench for rr_mux_arbiter (CNT=5).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

  localparam int C_WIDTH = 32;
  localparam int C_CNT   = 5;
  localparam int C_SRC_W = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_mux_arbiter_if #(.WIDTH(C_WIDTH), .CNT(C_CNT), .SRC_W(C_SRC_W)) bus ();

  rr_mux_arbiter #(.WIDTH(C_WIDTH), .CNT(C_CNT), .SRC_W(C_SRC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [C_WIDTH-1:0] v);
    bus.in_data[idx*C_WIDTH +: C_WIDTH] = v;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_vld   = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    bus.out_rdy  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n      = 1'b0;
    bus.in_vld = 5'b11111;
    tick();
    total++; if (bus.grant !== 5'b0)    begin bad++; $display("FAIL reset_grant: got %b want %b", bus.grant, 5'b0); end
    total++; if (bus.in_rdy !== 5'b0)   begin bad++; $display("FAIL reset_in_rdy: got %b want %b", bus.in_rdy, 5'b0); end
    total++; if (bus.out_vld !== 1'b0)  begin bad++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    total++; if (bus.out_data !== '0)   begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_src !== '0)    begin bad++; $display("FAIL reset_out_src: got %0d want 0", bus.out_src); end
    bus.in_vld = '0;
    rst_n      = 1'b1;
    tick();
    total++; if (bus.grant !== 5'b0)    begin bad++; $display("FAIL idle_grant: got %b want %b", bus.grant, 5'b0); end
  endtask

  task automatic test_rr_basic();
    do_reset();
    for (int i = 0; i < C_CNT; i++) set_data(i, 32'hA0 + i);
    bus.in_last = 5'b11111;
    bus.in_vld  = 5'b10100;
    tick();
    total++; if (bus.grant !== 5'b00100)  begin bad++; $display("FAIL basic_grant2: got %b want %b", bus.grant, 5'b00100); end
    total++; if (bus.in_rdy !== 5'b00100) begin bad++; $display("FAIL basic_rdy2: got %b want %b", bus.in_rdy, 5'b00100); end
    tick();
    total++; if (bus.out_vld !== 1'b1)    begin bad++; $display("FAIL basic_vld2: got %b want 1", bus.out_vld); end
    total++; if (bus.out_src !== 3'd2)    begin bad++; $display("FAIL basic_src2: got %0d want 2", bus.out_src); end
    total++; if (bus.out_data !== 32'hA2) begin bad++; $display("FAIL basic_data2: got %h want %h", bus.out_data, 32'hA2); end
    total++; if (bus.grant !== 5'b0)      begin bad++; $display("FAIL basic_idle: got %b want %b", bus.grant, 5'b0); end
    tick();
    total++; if (bus.grant !== 5'b10000)  begin bad++; $display("FAIL basic_grant4: got %b want %b", bus.grant, 5'b10000); end
    total++; if (bus.out_vld !== 1'b0)    begin bad++; $display("FAIL basic_drain: got %b want 0", bus.out_vld); end
    tick();
    total++; if (bus.out_src !== 3'd4)    begin bad++; $display("FAIL basic_src4: got %0d want 4", bus.out_src); end
    total++; if (bus.out_data !== 32'hA4) begin bad++; $display("FAIL basic_data4: got %h want %h", bus.out_data, 32'hA4); end
    bus.in_vld = '0;
    tick();
    total++; if (bus.grant !== 5'b0)      begin bad++; $display("FAIL basic_end: got %b want %b", bus.grant, 5'b0); end
  endtask

  task automatic test_all_five();
    logic [C_CNT-1:0] exp_g;
    do_reset();
    for (int i = 0; i < C_CNT; i++) set_data(i, 32'hA0 + i);
    bus.in_last = 5'b11111;
    bus.in_vld  = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      exp_g = 5'b00001 << (k % C_CNT);
      tick();
      total++; if (bus.grant !== exp_g)  begin bad++; $display("FAIL all5_grant[%0d]: got %b want %b", k, bus.grant, exp_g); end
      total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL all5_bubble[%0d]: got %b want 0", k, bus.out_vld); end
      tick();
      total++; if (bus.out_src !== C_SRC_W'(k % C_CNT)) begin bad++; $display("FAIL all5_src[%0d]: got %0d want %0d", k, bus.out_src, k % C_CNT); end
      total++; if (bus.out_data !== 32'hA0 + (k % C_CNT)) begin bad++; $display("FAIL all5_data[%0d]: got %h want %h", k, bus.out_data, 32'hA0 + (k % C_CNT)); end
    end
    bus.in_vld = '0;
    tick();
  endtask

  task automatic test_packet_hold();
    do_reset();
    bus.in_vld  = 5'b00010;
    bus.in_last = 5'b00000;
    set_data(1, 32'hB100);
    tick();
    total++; if (bus.grant !== 5'b00010) begin bad++; $display("FAIL pkt_grant: got %b want %b", bus.grant, 5'b00010); end
    bus.in_vld  = 5'b00011;
    bus.in_last = 5'b00001;
    set_data(0, 32'hC0);
    tick();
    total++; if (bus.out_data !== 32'hB100) begin bad++; $display("FAIL pkt_beat0: got %h want %h", bus.out_data, 32'hB100); end
    total++; if (bus.out_last !== 1'b0)     begin bad++; $display("FAIL pkt_last0: got %b want 0", bus.out_last); end
    total++; if (bus.grant !== 5'b00010)    begin bad++; $display("FAIL pkt_hold0: got %b want %b", bus.grant, 5'b00010); end
    set_data(1, 32'hB101);
    tick();
    total++; if (bus.out_data !== 32'hB101) begin bad++; $display("FAIL pkt_beat1: got %h want %h", bus.out_data, 32'hB101); end
    bus.in_vld = 5'b00001;
    tick();
    total++; if (bus.grant !== 5'b00010)    begin bad++; $display("FAIL pkt_bubble_grant: got %b want %b", bus.grant, 5'b00010); end
    total++; if (bus.out_vld !== 1'b0)      begin bad++; $display("FAIL pkt_bubble_vld: got %b want 0", bus.out_vld); end
    bus.in_vld  = 5'b00011;
    bus.in_last = 5'b00011;
    set_data(1, 32'hB102);
    tick();
    total++; if (bus.out_data !== 32'hB102) begin bad++; $display("FAIL pkt_beat2: got %h want %h", bus.out_data, 32'hB102); end
    total++; if (bus.out_last !== 1'b1)     begin bad++; $display("FAIL pkt_last2: got %b want 1", bus.out_last); end
    total++; if (bus.out_src !== 3'd1)      begin bad++; $display("FAIL pkt_src: got %0d want 1", bus.out_src); end
    total++; if (bus.grant !== 5'b0)        begin bad++; $display("FAIL pkt_release: got %b want %b", bus.grant, 5'b0); end
    bus.in_vld = 5'b00001;
    tick();
    total++; if (bus.grant !== 5'b00001)    begin bad++; $display("FAIL pkt_next_grant: got %b want %b", bus.grant, 5'b00001); end
    tick();
    total++; if (bus.out_data !== 32'hC0)   begin bad++; $display("FAIL pkt_next_data: got %h want %h", bus.out_data, 32'hC0); end
    bus.in_vld = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in_vld  = 5'b01000;
    bus.in_last = 5'b00000;
    set_data(3, 32'hD0);
    tick();
    total++; if (bus.grant !== 5'b01000) begin bad++; $display("FAIL bp_grant: got %b want %b", bus.grant, 5'b01000); end
    tick();
    bus.out_rdy = 1'b0;
    set_data(3, 32'hD1);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.in_rdy !== 5'b0)     begin bad++; $display("FAIL bp_rdy[%0d]: got %b want %b", k, bus.in_rdy, 5'b0); end
      tick();
      total++; if (bus.out_vld !== 1'b1)    begin bad++; $display("FAIL bp_vld[%0d]: got %b want 1", k, bus.out_vld); end
      total++; if (bus.out_data !== 32'hD0) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, bus.out_data, 32'hD0); end
      total++; if (bus.out_src !== 3'd3)    begin bad++; $display("FAIL bp_src[%0d]: got %0d want 3", k, bus.out_src); end
    end
    bus.out_rdy = 1'b1;
    #1;
    total++; if (bus.in_rdy !== 5'b01000)   begin bad++; $display("FAIL bp_resume_rdy: got %b want %b", bus.in_rdy, 5'b01000); end
    tick();
    total++; if (bus.out_data !== 32'hD1)   begin bad++; $display("FAIL bp_beat1: got %h want %h", bus.out_data, 32'hD1); end
    set_data(3, 32'hD2);
    bus.in_last = 5'b01000;
    tick();
    total++; if (bus.out_data !== 32'hD2)   begin bad++; $display("FAIL bp_beat2: got %h want %h", bus.out_data, 32'hD2); end
    total++; if (bus.out_last !== 1'b1)     begin bad++; $display("FAIL bp_last: got %b want 1", bus.out_last); end
    bus.in_vld = '0;
    tick();
    total++; if (bus.out_vld !== 1'b0)      begin bad++; $display("FAIL bp_drained: got %b want 0", bus.out_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_vld  = 5'b00100;
    bus.in_last = 5'b00000;
    set_data(2, 32'hE0);
    tick();
    tick();
    set_data(2, 32'hE1);
    tick();
    total++; if (bus.out_data !== 32'hE1) begin bad++; $display("FAIL rm_beat1: got %h want %h", bus.out_data, 32'hE1); end
    set_data(2, 32'hE2);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.grant !== 5'b0)    begin bad++; $display("FAIL rm_grant: got %b want %b", bus.grant, 5'b0); end
    total++; if (bus.in_rdy !== 5'b0)   begin bad++; $display("FAIL rm_rdy: got %b want %b", bus.in_rdy, 5'b0); end
    total++; if (bus.out_vld !== 1'b0)  begin bad++; $display("FAIL rm_vld: got %b want 0", bus.out_vld); end
    total++; if (bus.out_data !== '0)   begin bad++; $display("FAIL rm_data: got %h want 0", bus.out_data); end
    total++; if (bus.out_src !== '0)    begin bad++; $display("FAIL rm_src: got %0d want 0", bus.out_src); end
    tick();
    rst_n       = 1'b1;
    bus.in_vld  = 5'b11111;
    bus.in_last = 5'b11111;
    tick();
    total++; if (bus.grant !== 5'b00001) begin bad++; $display("FAIL rm_restart: got %b want %b", bus.grant, 5'b00001); end
    bus.in_vld = '0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_rr_basic();
    test_all_five();
    test_packet_hold();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // One-hot grant must hold at every sampled point.
  always @(negedge clk) begin
    if (rst_n && !$onehot0(bus.grant)) begin
      bad++;
      $display("FAIL grant_onehot: got %b want at most one bit", bus.grant);
    end
  end

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload bits per requester.
REQ-002 The block SHALL have parameter CNT, default 5, number of requesters (CNT >= 2).
REQ-003 The block SHALL have parameter SRC_W, default 3, width of the source index (2**SRC_W >= CNT).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all flops rise on clk.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in_vld, input, CNT, per-requester beat valid.
REQ-007 The block SHALL have port in_last, input, CNT, per-requester last beat of packet.
REQ-008 The block SHALL have port in_data, input, WIDTH*CNT, requester i payload at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_rdy, output, CNT, per-requester beat accept.
REQ-010 The block SHALL have port grant, output, CNT, registered one-hot mux select (all-zero when idle).
REQ-011 The block SHALL have port out_vld, output, 1, output beat valid.
REQ-012 The block SHALL have port out_last, output, 1, output last flag.
REQ-013 The block SHALL have port out_data, output, WIDTH, output payload.
REQ-014 The block SHALL have port out_src, output, SRC_W, binary index of the requester that sent the current output beat.
REQ-015 The block SHALL have port out_rdy, input, 1, downstream accept.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE (grant = 0) and BUSY (grant one-hot).
REQ-017 In IDLE with any in_vld set, the block SHALL pick a winner round-robin, scanning from pointer ptr upward with modulo-CNT wrap, then register grant and enter BUSY on the next edge.
REQ-018 In IDLE with in_vld = 0, the block SHALL stay in IDLE with grant held at 0.
REQ-019 Only in_vld SHALL drive arbitration; in_last and in_data of non-winners SHALL be ignored.
REQ-020 The block SHALL drive in_rdy[i] = grant[i] & (~out_vld | out_rdy) combinationally; in_rdy SHALL be 0 in IDLE.
REQ-021 A beat SHALL be accepted when in_vld[g] & in_rdy[g]; the datapath SHALL be the one-hot AND-OR mux of in_data selected by grant.
REQ-022 An accepted beat SHALL load out_data, out_last and out_src and set out_vld on the next edge (1-cycle latency).
REQ-023 With out_vld = 1 and out_rdy = 0, out_vld/out_data/out_last/out_src SHALL hold stable.
REQ-024 With out_vld = 1, out_rdy = 1 and no new accept, out_vld SHALL clear next edge; a simultaneous accept SHALL replace the beat (full throughput).
REQ-025 The grant SHALL hold for the whole packet; bubbles (in_vld[g] low in BUSY) SHALL not release it.
REQ-026 An accepted beat with in_last[g] = 1 SHALL return the FSM to IDLE, clear grant, and set ptr = (g+1) mod CNT on the next edge.
REQ-027 Back-to-back packets SHALL have exactly one IDLE cycle between last accept and the next grant.
REQ-028 ptr SHALL update only at packet end; a requester dropping in_vld in IDLE SHALL not change ptr.
REQ-029 grant SHALL never contain more than one set bit.

Reset
REQ-030 While rst_n = 0: state = IDLE, ptr = 0, grant = 0, out_vld = 0, out_last = 0, out_data = 0, out_src = 0, in_rdy = 0.
REQ-031 Reset mid-packet SHALL abandon the packet and the held output beat; after release arbitration restarts from ptr = 0.

Verification
REQ-032 CNT=5, reset, in_vld=5'b10100, single-beat packets, out_rdy=1 -> grant 5'b00100 then 5'b10000; out_src 2 then 4.
REQ-033 All five requesters continuously send 1-beat packets -> out_src sequence 0,1,2,3,4,0 with one bubble cycle between beats.
REQ-034 Requester 1 sends 3-beat packet while requester 0 requests -> grant stays 5'b00010 until in_last accept; requester 0 served next.
REQ-035 out_rdy=0 for 4 cycles with out_vld=1 -> output fields stable, in_rdy=0; on out_rdy=1 transfer resumes with no beat lost or duplicated.
REQ-036 rst_n asserted during beat 2 of 4 -> all outputs 0 same cycle; after release, in_vld=5'b11111 -> grant 5'b00001.
